outing_scheduler: RTL and testbench

Sequential controller that decides when the group goes out and which hiking-club member and which basketball-team member are granted the outing. It samples per-member requests and applies the rule "at least one member from each group". It then holds the outing for a fixed duration and enforces a cooldown. Within each group it rotates grants round-robin. It sits above the combinational going-out decision logic and drives the registered `going_out` flag consumed by the rest of the design.

---
 rtl/outing_scheduler.sv | 143 ++++++++++++++
 tb/tb_outing_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/outing_scheduler.sv
// outing_scheduler: decides when the group goes out and which hiking-club and
// basketball-team member each get the outing. A pair needs one requester from
// each group. Each outing is followed by a cooldown. Grants rotate round-robin
// within each group.
//
// state  | meaning
// IDLE   | no activity, watching requests
// GATHER | one group requesting, waiting for the other (bounded by WAIT_MAX)
// OUT    | outing in progress, grants frozen
// COOL   | cooldown after an outing, requests ignored
module outing_scheduler #(
  parameter int OUT_CYCLES  = 8,
  parameter int COOL_CYCLES = 2,
  parameter int WAIT_MAX    = 15
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] hike_req,
  input  logic [1:0] ball_req,
  input  logic       done_early,
  output logic       going_out,
  output logic [1:0] hike_gnt,
  output logic [1:0] ball_gnt,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] outing_count
);

  typedef enum logic [1:0] {IDLE, GATHER, OUT, COOL} state_t;

  localparam logic [7:0] OUT_LAST  = 8'(OUT_CYCLES - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOL_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] dur_cnt;
  logic [7:0] cool_cnt;
  logic       hptr;
  logic       bptr;

  logic       h;
  logic       b;
  logic       start_out;
  logic [1:0] hike_pick;
  logic [1:0] ball_pick;

  // Candidate grants for this cycle; the pointer only breaks ties when both members ask.
  always_comb begin
    h         = |hike_req;
    b         = |ball_req;
    start_out = ((state == IDLE) || (state == GATHER)) && h && b;
    hike_pick = 2'b00;
    ball_pick = 2'b00;
    case (hike_req)
      2'b01:   hike_pick = 2'b01;
      2'b10:   hike_pick = 2'b10;
      2'b11:   hike_pick = hptr ? 2'b10 : 2'b01;
      default: hike_pick = 2'b00;
    endcase
    case (ball_req)
      2'b01:   ball_pick = 2'b01;
      2'b10:   ball_pick = 2'b10;
      2'b11:   ball_pick = bptr ? 2'b10 : 2'b01;
      default: ball_pick = 2'b00;
    endcase
  end

  // Sequencer: state, timers, pointers and all registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      dur_cnt      <= 8'd0;
      cool_cnt     <= 8'd0;
      hptr         <= 1'b0;
      bptr         <= 1'b0;
      going_out    <= 1'b0;
      hike_gnt     <= 2'b00;
      ball_gnt     <= 2'b00;
      busy         <= 1'b0;
      timeout      <= 1'b0;
      outing_count <= 8'd0;
    end else begin
      timeout <= 1'b0;
      if (start_out) begin
        state     <= OUT;
        dur_cnt   <= 8'd0;
        going_out <= 1'b1;
        busy      <= 1'b1;
        hike_gnt  <= hike_pick;
        ball_gnt  <= ball_pick;
        // Pointer moves to whichever member was not granted.
        hptr      <= hike_pick[0];
        bptr      <= ball_pick[0];
        if (outing_count != 8'hFF) outing_count <= outing_count + 8'd1;
      end else begin
        case (state)
          IDLE: begin
            if (h ^ b) begin
              state    <= GATHER;
              wait_cnt <= 8'd0;
              busy     <= 1'b1;
            end
          end
          GATHER: begin
            if (!h && !b) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (wait_cnt == WAIT_LAST) begin
              state   <= IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          OUT: begin
            if (done_early || (dur_cnt == OUT_LAST)) begin
              state     <= COOL;
              cool_cnt  <= 8'd0;
              going_out <= 1'b0;
              hike_gnt  <= 2'b00;
              ball_gnt  <= 2'b00;
            end else begin
              dur_cnt <= dur_cnt + 8'd1;
            end
          end
          COOL: begin
            if (cool_cnt == COOL_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cool_cnt <= cool_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_outing_scheduler.sv
// Bench for outing_scheduler: a fixed vector table, hand-written corner
// sequences and randomized traffic, all checked against a phase/remaining-time
// reference model.
module tb_outing_scheduler;

  localparam int OUT_C  = 8;
  localparam int COOL_C = 2;
  localparam int WAIT_C = 15;

  logic       Clk;
  logic       Rst_n;
  logic [1:0] hike_req;
  logic [1:0] ball_req;
  logic       done_early;
  logic       going_out;
  logic [1:0] hike_gnt;
  logic [1:0] ball_gnt;
  logic       busy;
  logic       timeout;
  logic [7:0] outing_count;
  logic [14:0] dut_b;

  int n_vec = 0;
  int n_err = 0;

  outing_scheduler #(.OUT_CYCLES(OUT_C), .COOL_CYCLES(COOL_C), .WAIT_MAX(WAIT_C)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .hike_req(hike_req), .ball_req(ball_req),
    .done_early(done_early), .going_out(going_out), .hike_gnt(hike_gnt),
    .ball_gnt(ball_gnt), .busy(busy), .timeout(timeout), .outing_count(outing_count)
  );

  assign dut_b = {going_out, hike_gnt, ball_gnt, busy, timeout, outing_count};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // Reference model: phase 0 idle, 1 gather, 2 out, 3 cool; m_left = cycles remaining.
  int         m_phase, m_left, m_cnt;
  logic       m_hp, m_bp, m_tmo;
  logic [1:0] m_hg, m_bg;

  function automatic logic [14:0] pk(logic go, logic [1:0] hg, logic [1:0] bg,
                                     logic bs, logic tm, logic [7:0] c);
    return {go, hg, bg, bs, tm, c};
  endfunction

  function automatic logic [14:0] model_b();
    return pk(m_phase == 2, (m_phase == 2) ? m_hg : 2'b00, (m_phase == 2) ? m_bg : 2'b00,
              m_phase != 0, m_tmo, m_cnt[7:0]);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_cnt = 0;
    m_hp = 1'b0; m_bp = 1'b0; m_tmo = 1'b0;
    m_hg = 2'b00; m_bg = 2'b00;
  endtask

  task automatic pick(input logic [1:0] req, input logic ptr,
                      output logic [1:0] g, output logic np);
    if (req == 2'b11) g = ptr ? 2'b10 : 2'b01;
    else g = req;
    np = (g == 2'b01);
  endtask

  task automatic model_start(input logic [1:0] hr, input logic [1:0] br);
    logic [1:0] g;
    logic np;
    pick(hr, m_hp, g, np); m_hg = g; m_hp = np;
    pick(br, m_bp, g, np); m_bg = g; m_bp = np;
    m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
    m_phase = 2;
    m_left  = OUT_C;
  endtask

  task automatic model_step(input logic [1:0] hr, input logic [1:0] br, input logic d);
    logic h, b;
    h = |hr;
    b = |br;
    m_tmo = 1'b0;
    case (m_phase)
      0: if (h && b) model_start(hr, br);
         else if (h || b) begin m_phase = 1; m_left = WAIT_C; end
      1: if (h && b) model_start(hr, br);
         else if (!h && !b) m_phase = 0;
         else begin
           m_left--;
           if (m_left == 0) begin m_phase = 0; m_tmo = 1'b1; end
         end
      2: begin
           m_left--;
           if (d || m_left == 0) begin m_phase = 3; m_left = COOL_C; end
         end
      default: begin
           m_left--;
           if (m_left == 0) m_phase = 0;
         end
    endcase
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [1:0] hr, input logic [1:0] br, input logic d);
    hike_req = hr; ball_req = br; done_early = d;
    @(posedge Clk);
    model_step(hr, br, d);
    #1;
    check("model", 32'(dut_b), 32'(model_b()));
  endtask

  task automatic apply_reset();
    Rst_n = 1'b0;
    #1;
    check("async_rst", 32'(dut_b), 32'd0);
    model_reset();
    #1;
    Rst_n = 1'b1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(2'b00, 2'b00, 1'b0);
  endtask

  typedef struct {
    logic [1:0]  h;
    logic [1:0]  b;
    logic        d;
    logic [14:0] exp;
  } vec_t;

  vec_t       tbl[12];
  logic [3:0] rr_exp[3];

  initial begin
    int w;
    logic [1:0] hr, br;
    Rst_n = 1'b1; hike_req = 2'b00; ball_req = 2'b00; done_early = 1'b0;
    model_reset();
    #2;
    apply_reset();

    // Round robin with both groups requesting continuously.
    rr_exp[0] = 4'b0101; rr_exp[1] = 4'b1010; rr_exp[2] = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      do begin tick(2'b11, 2'b11, 1'b0); w++; end while (!going_out && w < 20);
      check("rr_enter", 32'(going_out), 32'd1);
      check($sformatf("rr_grant_%0d", k), 32'({hike_gnt, ball_gnt}), 32'(rr_exp[k]));
      w = 0;
      while (going_out && w < 20) begin tick(2'b11, 2'b11, 1'b0); w++; end
      check("rr_leave", 32'(going_out), 32'd0);
    end
    check("rr_count", 32'(outing_count), 32'd3);
    apply_reset();

    // Basic outing as a table: 8 OUT cycles, 2 COOL cycles, then IDLE.
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        tbl[i] = '{h: 2'b01, b: 2'b10, d: 1'b0,
                   exp: pk(1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 8'd1)};
      end else if (i < 10) begin
        tbl[i] = '{h: 2'b00, b: 2'b00, d: 1'b0,
                   exp: pk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 8'd1)};
      end else begin
        tbl[i] = '{h: 2'b00, b: 2'b00, d: 1'b0,
                   exp: pk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'd1)};
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].h, tbl[i].b, tbl[i].d);
      check($sformatf("basic_%0d", i), 32'(dut_b), 32'(tbl[i].exp));
    end

    // Timeout: GATHER lasts WAIT_C cycles, then a single-cycle pulse.
    apply_reset();
    tick(2'b10, 2'b00, 1'b0);
    check("to_busy", 32'(busy), 32'd1);
    for (int i = 2; i <= WAIT_C; i++) begin
      tick(2'b10, 2'b00, 1'b0);
      check("to_early", 32'({busy, timeout}), 32'b10);
    end
    tick(2'b10, 2'b00, 1'b0);
    check("to_pulse", 32'({busy, timeout, hike_gnt}), 32'b0100);
    tick(2'b00, 2'b00, 1'b0);
    check("to_clear", 32'(timeout), 32'd0);
    check("to_count", 32'(outing_count), 32'd0);

    // Late pair: ball request arrives 5 cycles into GATHER.
    tick(2'b01, 2'b00, 1'b0);
    for (int i = 2; i <= 5; i++) tick(2'b01, 2'b00, 1'b0);
    tick(2'b01, 2'b01, 1'b0);
    check("late_out", 32'({going_out, timeout, hike_gnt, ball_gnt}), 32'b1_0_01_01);
    idle_ticks(12);

    // Pair completed exactly in the last GATHER cycle: OUT wins over timeout.
    tick(2'b01, 2'b00, 1'b0);
    for (int i = 2; i <= WAIT_C; i++) tick(2'b01, 2'b00, 1'b0);
    tick(2'b01, 2'b01, 1'b0);
    check("edge_out", 32'({going_out, timeout}), 32'b10);
    idle_ticks(12);

    // Abort in the 3rd OUT cycle.
    tick(2'b01, 2'b01, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
    check("abort_pre", 32'(going_out), 32'd1);
    tick(2'b00, 2'b00, 1'b1);
    check("abort_cut", 32'({going_out, busy}), 32'b01);
    tick(2'b00, 2'b00, 1'b0);
    check("abort_cool2", 32'({going_out, busy}), 32'b01);
    tick(2'b00, 2'b00, 1'b0);
    check("abort_idle", 32'({going_out, busy}), 32'b00);

    // Asynchronous reset mid-OUT also returns the pointers to 0.
    apply_reset();
    tick(2'b11, 2'b11, 1'b0);
    check("ptr_first", 32'({hike_gnt, ball_gnt}), 32'b0101);
    tick(2'b00, 2'b00, 1'b0);
    apply_reset();
    tick(2'b11, 2'b11, 1'b0);
    check("ptr_after_rst", 32'({hike_gnt, ball_gnt}), 32'b0101);

    // Saturation: 260 short outings.
    for (int i = 0; i < 260 * 4; i++) tick(2'b01, 2'b01, 1'b1);
    check("sat_count", 32'(outing_count), 32'd255);
    idle_ticks(4);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      hr = 2'($urandom_range(0, 3));
      br = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) hr = 2'b00;
      if ($urandom_range(0, 2) == 0) br = 2'b00;
      tick(hr, br, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 499) == 0) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
